jtkicker_ncolmix: RTL and testbench

JTKICKER_NCOLMIX -- requirements
Module: jtkicker_ncolmix

---
 rtl/jtkicker_ncolmix.sv | 98 +++++++++
 tb/tb_jtkicker_ncolmix.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jtkicker_ncolmix.sv
// Colour mixer: picks the highest-priority visible layer pixel, looks it up
// in a programmable 8-bit palette and expands it to 4-bit RGB. Three pixel
// stages (select, palette read, expand) all advance on pxl_cen. Blanking is
// delayed separately for the LHBL_dly/LVBL_dly outputs and, through a fixed
// two-stage tap, used to blank the colour so it lines up with the pixel path.
module jtkicker_ncolmix #(
   parameter int LAYERS    = 2,
   parameter int PXLW      = 4,
   parameter int BLANK_DLY = 3,
   localparam int PALW     = PXLW + 2
) (
   input  logic                   rst,
   input  logic                   clk,
   input  logic                   pxl_cen,
   input  logic [LAYERS*PXLW-1:0] lyr_pxl,
   input  logic                   LHBL,
   input  logic                   LVBL,
   input  logic [PALW-1:0]        prog_addr,
   input  logic [7:0]             prog_data,
   input  logic                   prog_en,
   input  logic [3:0]             gfx_en,
   output logic [3:0]             red,
   output logic [3:0]             green,
   output logic [3:0]             blue,
   output logic                   LHBL_dly,
   output logic                   LVBL_dly
);

   logic [1:0]           sel_lyr;
   logic [PXLW-1:0]      sel_pxl;
   logic [PALW-1:0]      idx;
   logic [7:0]           pal_q;
   logic [7:0]           pal [0:2**PALW-1];
   logic [BLANK_DLY-1:0] hbl_sr;
   logic [BLANK_DLY-1:0] vbl_sr;
   logic [1:0]           blank_pipe;

   // Priority pick: scan from the top layer down so the lowest qualifying
   // layer is the last assignment; nothing qualifying leaves the top layer
   // with pen 0, which still indexes a real palette entry.
   always_comb begin
      sel_lyr = 2'(LAYERS-1);
      sel_pxl = '0;
      for (int n = LAYERS-1; n >= 0; n--) begin
         if (gfx_en[n] && (lyr_pxl[n*PXLW +: PXLW] != '0)) begin
            sel_lyr = 2'(n);
            sel_pxl = lyr_pxl[n*PXLW +: PXLW];
         end
      end
   end

   // Palette write port, free-running and never cleared by reset.
   always_ff @(posedge clk) begin
      if (prog_en) pal[prog_addr] <= prog_data;
   end

   // Pixel pipeline: stage 1 index, stage 2 palette read (old data on a
   // same-cycle write), stage 3 colour expansion with blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         pal_q <= '0;
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (pxl_cen) begin
         idx   <= {sel_lyr, sel_pxl};
         pal_q <= pal[idx];
         if (!blank_pipe[1]) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end else begin
            red   <= {pal_q[7:5], pal_q[7]};
            green <= {pal_q[4:2], pal_q[4]};
            blue  <= {pal_q[1:0], pal_q[1:0]};
         end
      end
   end

   // Blanking delays: configurable taps for the outputs, fixed two-stage
   // tap feeding stage 3 so colour blanking tracks the pixel it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hbl_sr     <= '0;
         vbl_sr     <= '0;
         blank_pipe <= '0;
      end else if (pxl_cen) begin
         hbl_sr     <= (hbl_sr << 1) | BLANK_DLY'(LHBL);
         vbl_sr     <= (vbl_sr << 1) | BLANK_DLY'(LVBL);
         blank_pipe <= {blank_pipe[0], LHBL & LVBL};
      end
   end

   assign LHBL_dly = hbl_sr[BLANK_DLY-1];
   assign LVBL_dly = vbl_sr[BLANK_DLY-1];

endmodule

// File: tb/tb_jtkicker_ncolmix.sv
// Bench for jtkicker_ncolmix: directed pixel vectors feed a scoreboard of
// expected colours keyed by the pxl_cen pulse on which they must appear.
module tb_jtkicker_ncolmix;

   localparam int LAYERS    = 2;
   localparam int PXLW      = 4;
   localparam int BLANK_DLY = 5;
   localparam int PALW      = PXLW + 2;

   logic                   rst, clk, pxl_cen;
   logic [LAYERS*PXLW-1:0] lyr_pxl;
   logic                   LHBL, LVBL;
   logic [PALW-1:0]        prog_addr;
   logic [7:0]             prog_data;
   logic                   prog_en;
   logic [3:0]             gfx_en;
   logic [3:0]             red, green, blue;
   logic                   LHBL_dly, LVBL_dly;

   jtkicker_ncolmix #(.LAYERS(LAYERS), .PXLW(PXLW), .BLANK_DLY(BLANK_DLY)) dut (
      .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .lyr_pxl(lyr_pxl),
      .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_en(prog_en), .gfx_en(gfx_en), .red(red), .green(green), .blue(blue),
      .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [11:0] rgb;
      string       nm;
   } exp_t;

   typedef struct {
      logic [7:0]  px;
      logic [3:0]  ge;
      logic [11:0] rgb;
      string       nm;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pcnt = 0;
   logic cen_s = 0, rst_s = 1;
   logic [13:0] pre = '0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endfunction

   // pulse counter and pre-edge snapshot for the hold check
   always @(posedge clk) begin
      if (pxl_cen && !rst) pcnt <= pcnt + 1;
      cen_s <= pxl_cen;
      rst_s <= rst;
      pre   <= {red, green, blue, LHBL_dly, LVBL_dly};
   end

   // monitor: pop the expectation due on this pulse; also outputs must hold
   // across clocks without pxl_cen
   always @(negedge clk) begin
      if (!rst && sb.size() > 0 && sb[0].due == pcnt) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.nm, {20'h0, red, green, blue}, {20'h0, e.rgb});
      end
      if (!cen_s && !rst_s && !rst)
         chk("hold", {18'h0, red, green, blue, LHBL_dly, LVBL_dly}, {18'h0, pre});
   end

   task automatic prog(input logic [PALW-1:0] a, input logic [7:0] d);
      prog_addr = a; prog_data = d; prog_en = 1;
      @(negedge clk);
      prog_en = 0;
   endtask

   // one pxl_cen pulse followed by one idle clock; called at a negedge
   task automatic pulse(input logic [7:0] px, input logic [3:0] ge, input logic hb,
                        input bit tag, input logic [11:0] rgb, input string nm);
      lyr_pxl = px; gfx_en = ge; LHBL = hb; LVBL = 1; pxl_cen = 1;
      if (tag) sb.push_back('{pcnt + 3, rgb, nm});
      @(negedge clk);
      pxl_cen = 0; prog_en = 0;
      @(negedge clk);
   endtask

   vec_t vecs [8] = '{
      '{8'h35, 4'hF, 12'h0F0, "prio"},
      '{8'h35, 4'hE, 12'hF00, "l0_off"},
      '{8'h00, 4'hF, 12'h00F, "transp"},
      '{8'hF1, 4'hF, 12'h99A, "mixed"},
      '{8'hF1, 4'h2, 12'h445, "l1_only"},
      '{8'h05, 4'h1, 12'h0F0, "l0_only"},
      '{8'h35, 4'h0, 12'h00F, "none_en"},
      '{8'h35, 4'hC, 12'h00F, "hi_bits"}
   };

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int pb;
      rst = 1; pxl_cen = 0; lyr_pxl = '0; LHBL = 1; LVBL = 1;
      prog_addr = '0; prog_data = '0; prog_en = 0; gfx_en = 4'hF;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rgb",  {20'h0, red, green, blue}, 32'h0);
      chk("rst_hdly", {31'h0, LHBL_dly}, 32'h0);
      chk("rst_vdly", {31'h0, LVBL_dly}, 32'h0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      prog(6'h13, 8'hE0);
      prog(6'h05, 8'h1C);
      prog(6'h10, 8'h03);
      prog(6'h01, 8'h92);
      prog(6'h1F, 8'h49);

      // fill the blanking delay lines
      for (int i = 0; i < 6; i++) pulse(8'h00, 4'hF, 1, 0, '0, "");
      chk("warm_hdly", {31'h0, LHBL_dly}, 32'h1);
      chk("warm_vdly", {31'h0, LVBL_dly}, 32'h1);

      foreach (vecs[i]) pulse(vecs[i].px, vecs[i].ge, 1, 1, vecs[i].rgb, vecs[i].nm);

      // one-pulse horizontal blank
      pb = pcnt + 1;
      pulse(8'h35, 4'hF, 0, 1, 12'h000, "blank_rgb");
      chk("blank_hdly", {31'h0, LHBL_dly}, 32'h1);
      for (int i = 1; i < 8; i++) begin
         pulse(8'h35, 4'hF, 1, 1, 12'h0F0, "after_blank");
         chk("blank_hdly", {31'h0, LHBL_dly}, (pcnt == pb + 4) ? 32'h0 : 32'h1);
         chk("blank_vdly", {31'h0, LVBL_dly}, 32'h1);
      end

      // write collision on the entry being read
      pulse(8'h05, 4'hF, 1, 1, 12'h0F0, "coll_old");
      prog_addr = 6'h05; prog_data = 8'hFF; prog_en = 1;
      pulse(8'h05, 4'hF, 1, 1, 12'hFFF, "coll_new");
      for (int i = 0; i < 3; i++) pulse(8'h00, 4'hF, 1, 0, '0, "");

      // reset in the middle of a line
      for (int i = 0; i < 4; i++) pulse(8'h35, 4'hE, 1, 1, 12'hF00, "pre_rst");
      chk("pre_rst_red", {28'h0, red}, 32'hF);
      sb.delete();
      rst = 1;
      #1;
      chk("mid_rst_rgb",  {20'h0, red, green, blue}, 32'h0);
      chk("mid_rst_hdly", {31'h0, LHBL_dly}, 32'h0);
      chk("mid_rst_vdly", {31'h0, LVBL_dly}, 32'h0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      pulse(8'h35, 4'hE, 1, 1, 12'hF00, "post_rst_3rd");
      chk("post_rst_1", {20'h0, red, green, blue}, 32'h0);
      pulse(8'h35, 4'hE, 1, 0, '0, "");
      chk("post_rst_2", {20'h0, red, green, blue}, 32'h0);
      pulse(8'h35, 4'hE, 1, 0, '0, "");
      pulse(8'h00, 4'hF, 1, 0, '0, "");

      chk("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
